btb_update_arbiter: RTL

- Owns the single write port of the branch target buffer (BTB).
- Arbitrates between two requesters:
  - fetch-time allocations of newly seen branches, which are speculative and buffered;
  - retire-time direction corrections, which are non-speculative and never stalled.
- After reset, sequences a full BTB clear sweep before any other write.
- Sits between fetch/branch-prediction logic and the BTB storage.

---
 rtl/btb_update_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/btb_update_arbiter.sv
// btb_update_arbiter
// Owns the single write port of the branch target buffer. After reset it
// sweeps every BTB entry with a CLEAR write, then arbitrates between
// non-speculative retire-time corrections (always win, never stalled) and
// speculative fetch-time allocations (buffered in a small FIFO that a
// pipeline flush discards).
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   alloc_valid/ready     allocation handshake (accepted when both high)
//   alloc_index/pc/target/instruction  allocation payload
//   corr_valid/index/taken             direction correction from retire
//   flush                 discards all buffered allocations
//   wr_en/mode/index/pc/target/instruction/taken  registered BTB write port
//   init_done             clear sweep complete
//   fifo_count            pending allocations in the FIFO
module btb_update_arbiter #(
    parameter int BTB_SIZE         = 16,
    parameter int ADDRESS_SIZE     = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int FIFO_DEPTH       = 4,
    localparam int IDX_W           = $clog2(BTB_SIZE),
    localparam int PTR_W           = $clog2(FIFO_DEPTH),
    localparam int CNT_W           = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [IDX_W-1:0]            alloc_index,
    input  logic [ADDRESS_SIZE-1:0]     alloc_pc,
    input  logic [ADDRESS_SIZE-1:0]     alloc_target,
    input  logic [INSTRUCTION_SIZE-1:0] alloc_instruction,
    input  logic                        corr_valid,
    input  logic [IDX_W-1:0]            corr_index,
    input  logic                        corr_taken,
    input  logic                        flush,
    output logic                        wr_en,
    output logic [1:0]                  wr_mode,
    output logic [IDX_W-1:0]            wr_index,
    output logic [ADDRESS_SIZE-1:0]     wr_pc,
    output logic [ADDRESS_SIZE-1:0]     wr_target,
    output logic [INSTRUCTION_SIZE-1:0] wr_instruction,
    output logic                        wr_taken,
    output logic                        init_done,
    output logic [CNT_W-1:0]            fifo_count
);

    localparam logic [1:0] MODE_CLEAR   = 2'd0;
    localparam logic [1:0] MODE_ALLOC   = 2'd1;
    localparam logic [1:0] MODE_CORRECT = 2'd2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                        r_state;
    state_t                        w_nextState;
    logic [IDX_W-1:0]              r_sweep;

    logic [IDX_W-1:0]              r_fifoIndex [FIFO_DEPTH];
    logic [ADDRESS_SIZE-1:0]       r_fifoPc    [FIFO_DEPTH];
    logic [ADDRESS_SIZE-1:0]       r_fifoTarget[FIFO_DEPTH];
    logic [INSTRUCTION_SIZE-1:0]   r_fifoInstr [FIFO_DEPTH];
    logic [PTR_W-1:0]              r_rdPtr;
    logic [PTR_W-1:0]              r_wrPtr;
    logic [CNT_W-1:0]              r_count;

    logic                          w_push;
    logic                          w_pop;
    logic                          w_wrEn;
    logic [1:0]                    w_wrMode;
    logic [IDX_W-1:0]              w_wrIndex;
    logic [ADDRESS_SIZE-1:0]       w_wrPc;
    logic [ADDRESS_SIZE-1:0]       w_wrTarget;
    logic [INSTRUCTION_SIZE-1:0]   w_wrInstr;
    logic                          w_wrTaken;

    // Ready looks only at the current count, so a same-cycle pop never
    // makes room for a same-cycle push.
    assign alloc_ready = (r_state == ST_RUN) && (r_count < CNT_W'(FIFO_DEPTH)) && !flush;
    assign w_push      = alloc_valid && alloc_ready;
    assign init_done   = (r_state == ST_RUN);
    assign fifo_count  = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == ST_INIT && r_sweep == IDX_W'(BTB_SIZE - 1)) begin
            w_nextState = ST_RUN;
        end
    end

    // Write decision: sweep during INIT, otherwise correction beats the
    // FIFO head. Flush does not suppress a correction.
    always_comb begin
        w_wrEn     = 1'b0;
        w_wrMode   = MODE_CLEAR;
        w_wrIndex  = '0;
        w_wrPc     = '0;
        w_wrTarget = '0;
        w_wrInstr  = '0;
        w_wrTaken  = 1'b0;
        w_pop      = 1'b0;
        if (r_state == ST_INIT) begin
            w_wrEn    = 1'b1;
            w_wrIndex = r_sweep;
        end else if (corr_valid) begin
            w_wrEn    = 1'b1;
            w_wrMode  = MODE_CORRECT;
            w_wrIndex = corr_index;
            w_wrTaken = corr_taken;
        end else if (r_count != '0) begin
            w_pop      = 1'b1;
            w_wrEn     = 1'b1;
            w_wrMode   = MODE_ALLOC;
            w_wrIndex  = r_fifoIndex[r_rdPtr];
            w_wrPc     = r_fifoPc[r_rdPtr];
            w_wrTarget = r_fifoTarget[r_rdPtr];
            w_wrInstr  = r_fifoInstr[r_rdPtr];
            w_wrTaken  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en          <= 1'b0;
            wr_mode        <= MODE_CLEAR;
            wr_index       <= '0;
            wr_pc          <= '0;
            wr_target      <= '0;
            wr_instruction <= '0;
            wr_taken       <= 1'b0;
        end else begin
            wr_en          <= w_wrEn;
            wr_mode        <= w_wrMode;
            wr_index       <= w_wrIndex;
            wr_pc          <= w_wrPc;
            wr_target      <= w_wrTarget;
            wr_instruction <= w_wrInstr;
            wr_taken       <= w_wrTaken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sweep <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    // Payload storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoIndex[r_wrPtr]  <= alloc_index;
            r_fifoPc[r_wrPtr]     <= alloc_pc;
            r_fifoTarget[r_wrPtr] <= alloc_target;
            r_fifoInstr[r_wrPtr]  <= alloc_instruction;
        end
    end

    // Flush drops every buffered entry; alloc_ready is low during flush so
    // no push can race with the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (flush && r_state == ST_RUN) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
